// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_e      : arbiter FSM states (IDLE, ACCESS, RESP)
//   PORT_I/D     : port identifiers used for grant and ack steering
//   *_DEF        : default parameter values for the top module
//   CNT_W        : width of the access-latency counter (MEM_LAT <= 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ADDR_W_DEF    = 18;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_LAT_DEF   = 2;
  localparam int MEM_WORDS_DEF = 32;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch (I) and data (D) requests.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined   : one-bit preferred-port pointer, toggles away from every winner
//   undefined : fixed priority, D over I; no pointer register
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer resets to D)
//   i_req      : fetch request
//   d_req      : data request
//   grant_en   : a grant is taken this cycle (IDLE with a request pending)
//   win_port   : PORT_I / PORT_D winner, valid whenever a request is high
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic win_port
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  always_comb begin
    win_port = PORT_D;
    ptr_d    = ptr_q;
    if (i_req && d_req) begin
      win_port = ptr_q;
    end else if (i_req) begin
      win_port = PORT_I;
    end
    // A lone request also moves the pointer away from its winner.
    if (grant_en) begin
      ptr_d = ~win_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PORT_D;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win_port = d_req ? PORT_D : PORT_I;

  // Fixed priority needs no state and never looks at the I request.
  logic unused_sel;
  assign unused_sel = ^{clk, rst_n, i_req, grant_en};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch (I, read-only)
// and data access (D, read/write, word or byte). One request is latched, the
// memory strobes are held for MEM_LAT cycles, read data is captured on the last
// of those cycles and a one-cycle ack is returned to the granted port.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_select).
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   i_req/i_addr -> i_ack/i_rdata    : fetch port
//   d_req/d_we/d_byte/d_addr/d_wdata : data port request
//   d_ack/d_rdata                    : data port completion
//   addr_err                         : pulses with ack for out-of-range requests
//   mem_*                            : memory address, write data and strobes
//   mem_read_data                    : memory read data
//   busy                             : FSM not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              mem_byteOperations,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] WORDS_LIM = ADDR_W'(MEM_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic              port_q, port_d;
  logic              err_q, err_d;

  logic              grant;
  logic              win_port;
  logic [ADDR_W-1:0] win_addr;

  assign grant    = (state_q == IDLE) && (i_req || d_req);
  assign win_addr = (win_port == PORT_D) ? d_addr : i_addr;

  mem_arb_select u_select (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .d_req    (d_req),
    .grant_en (grant),
    .win_port (win_port)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    port_d  = port_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          port_d  = win_port;
          addr_d  = win_addr;
          err_d   = (win_addr >= WORDS_LIM);
          // Fetch has no write path; D-side controls are ignored for it.
          we_d    = (win_port == PORT_D) ? d_we    : 1'b0;
          byte_d  = (win_port == PORT_D) ? d_byte  : 1'b0;
          wdata_d = (win_port == PORT_D) ? d_wdata : '0;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          // Response data is formatted here so RESP only has to steer it.
          if (err_q || we_q) begin
            rdata_d = '0;
          end else if (byte_q) begin
            rdata_d = {{(DATA_W-8){1'b0}}, mem_read_data[7:0]};
          end else begin
            rdata_d = mem_read_data;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      port_q  <= PORT_I;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    mem_address        = '0;
    mem_write_data     = '0;
    mem_memRead        = 1'b0;
    mem_memWrite       = 1'b0;
    mem_byteOperations = 1'b0;
    i_ack              = 1'b0;
    d_ack              = 1'b0;
    i_rdata            = '0;
    d_rdata            = '0;
    addr_err           = 1'b0;
    busy               = (state_q != IDLE);
    if (state_q == ACCESS) begin
      mem_address    = addr_q;
      mem_write_data = wdata_q;
      if (!err_q) begin
        mem_memRead        = ~we_q;
        mem_memWrite       = we_q;
        mem_byteOperations = byte_q;
      end
    end
    if (state_q == RESP) begin
      i_ack    = (port_q == PORT_I);
      d_ack    = (port_q == PORT_D);
      i_rdata  = (port_q == PORT_I) ? rdata_q : '0;
      d_rdata  = (port_q == PORT_D) ? rdata_q : '0;
      addr_err = err_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int WORDS = 32;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [17:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [17:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        addr_err;
  logic [17:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic        mem_byteOperations;
  logic [31:0] mem_read_data;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_W(18), .DATA_W(32), .MEM_LAT(LAT), .MEM_WORDS(WORDS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_req              (i_req),
    .i_addr             (i_addr),
    .i_ack              (i_ack),
    .i_rdata            (i_rdata),
    .d_req              (d_req),
    .d_we               (d_we),
    .d_byte             (d_byte),
    .d_addr             (d_addr),
    .d_wdata            (d_wdata),
    .d_ack              (d_ack),
    .d_rdata            (d_rdata),
    .addr_err           (addr_err),
    .mem_address        (mem_address),
    .mem_write_data     (mem_write_data),
    .mem_memRead        (mem_memRead),
    .mem_memWrite       (mem_memWrite),
    .mem_byteOperations (mem_byteOperations),
    .mem_read_data      (mem_read_data),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device driven by the DUT strobes.
  logic [31:0] mem_dev [WORDS];
  // Reference contents, updated only from completed transactions.
  logic [31:0] mem_ref [WORDS];

  assign mem_read_data = (mem_memRead && mem_address < 18'(WORDS)) ?
                         mem_dev[mem_address[4:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_memWrite && mem_address < 18'(WORDS)) begin
      if (mem_byteOperations) mem_dev[mem_address[4:0]][7:0] = mem_write_data[7:0];
      else                    mem_dev[mem_address[4:0]]      = mem_write_data;
    end
  end

  typedef struct {
    bit          v;
    bit          we;
    bit          byt;
    logic [17:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t pend_i, pend_d;
  bit   ptr_m;          // preferred port in the reference model, 1 = D
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit we, input bit byt, input logic [17:0] a, input logic [31:0] wd);
    txn_t t;
    t.v = 1'b1; t.we = we; t.byt = byt; t.addr = a; t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    logic [17:0] a;
    if ($urandom_range(0, 7) == 0) a = 18'($urandom_range(32, 1000));
    else                           a = 18'($urandom_range(0, WORDS-1));
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic drive_inputs();
    i_req   = pend_i.v;
    i_addr  = pend_i.addr;
    d_req   = pend_d.v;
    d_we    = pend_d.we;
    d_byte  = pend_d.byt;
    d_addr  = pend_d.addr;
    d_wdata = pend_d.wdata;
  endtask

  // Runs one transaction from the current pending set. Entered #1 after a
  // rising edge with the DUT idle; returns at the same point of the next idle cycle.
  task automatic run_txn(output bit won_d);
    txn_t        t;
    bit          w;
    bit          err;
    logic [31:0] exp_rd;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ack", 32'({i_ack, d_ack}), 32'd0);
    drive_inputs();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (pend_i.v && pend_d.v) w = ptr_m;
    else                      w = pend_d.v;
`else
    w = pend_d.v;
`endif
    t = w ? pend_d : pend_i;
    if (!w) begin t.we = 1'b0; t.byt = 1'b0; end
    err = (t.addr >= 18'(WORDS));
    if (err || t.we) exp_rd = 32'd0;
    else if (t.byt)  exp_rd = {24'd0, mem_ref[t.addr[4:0]][7:0]};
    else             exp_rd = mem_ref[t.addr[4:0]];
    @(posedge clk);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_rd_strobe", 32'(mem_memRead), 32'(!err && !t.we));
      chk("acc_wr_strobe", 32'(mem_memWrite), 32'(!err && t.we));
      chk("acc_no_ack", 32'({i_ack, d_ack}), 32'd0);
      if (!err) begin
        chk("acc_addr", 32'(mem_address), 32'(t.addr));
        chk("acc_byte", 32'(mem_byteOperations), 32'(t.byt));
        if (t.we) chk("acc_wdata", mem_write_data, t.wdata);
      end else begin
        chk("acc_err_byte", 32'(mem_byteOperations), 32'd0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("resp_i_ack", 32'(i_ack), 32'(!w));
    chk("resp_d_ack", 32'(d_ack), 32'(w));
    chk("resp_i_rdata", i_rdata, w ? 32'd0 : exp_rd);
    chk("resp_d_rdata", d_rdata, w ? exp_rd : 32'd0);
    chk("resp_addr_err", 32'(addr_err), 32'(err));
    chk("resp_strobes", 32'({mem_memRead, mem_memWrite}), 32'd0);
    @(posedge clk);
    #1;
    if (!err && t.we) begin
      if (t.byt) mem_ref[t.addr[4:0]][7:0] = t.wdata[7:0];
      else       mem_ref[t.addr[4:0]]      = t.wdata;
    end
    ptr_m = ~w;
    if (w) pend_d.v = 1'b0;
    else   pend_i.v = 1'b0;
    drive_inputs();
    won_d = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend_i.v = 1'b0;
    pend_d.v = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit       w;
    logic [5:0] order;
    logic [5:0] exp_order;
    int       cnt_i, cnt_d;

    for (int i = 0; i < WORDS; i++) begin
      mem_dev[i] = $urandom;
      mem_ref[i] = mem_dev[i];
    end
    pend_i = mk(1'b0, 1'b0, 18'd0, 32'd0);
    pend_d = mk(1'b0, 1'b0, 18'd0, 32'd0);
    pend_i.v = 1'b0;
    pend_d.v = 1'b0;
    ptr_m = 1'b1;
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack, addr_err}), 32'd0);
    chk("rst_strobes", 32'({mem_memRead, mem_memWrite, mem_byteOperations}), 32'd0);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);

    // Contention: both ports hold three reads each
    order = '0;
    cnt_i = 0;
    cnt_d = 0;
    pend_i = mk(1'b0, 1'b0, 18'($urandom_range(0, WORDS-1)), 32'd0);
    pend_d = mk(1'b0, 1'b0, 18'($urandom_range(0, WORDS-1)), 32'd0);
    for (int k = 0; k < 6; k++) begin
      run_txn(w);
      order = {order[4:0], w};
      if (w) begin
        cnt_d++;
        if (cnt_d < 3) pend_d = mk(1'b0, 1'b0, 18'($urandom_range(0, WORDS-1)), 32'd0);
      end else begin
        cnt_i++;
        if (cnt_i < 3) pend_i = mk(1'b0, 1'b0, 18'($urandom_range(0, WORDS-1)), 32'd0);
      end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = 6'b101010;
`else
    exp_order = 6'b111000;
`endif
    chk("contention_order", 32'(order), 32'(exp_order));

    // Word read of 32'hDEADBEEF at address 5
    mem_dev[5] = 32'hDEADBEEF;
    mem_ref[5] = 32'hDEADBEEF;
    pend_d = mk(1'b0, 1'b0, 18'd5, 32'd0);
    run_txn(w);
    chk("deadbeef_port", 32'(w), 32'd1);

    // Byte write then byte read-back at address 3
    pend_d = mk(1'b1, 1'b1, 18'd3, 32'h123456A7);
    run_txn(w);
    chk("byte_wr_mem", 32'(mem_dev[3][7:0]), 32'h000000A7);
    pend_d = mk(1'b0, 1'b1, 18'd3, 32'd0);
    run_txn(w);

    // Out-of-range fetch; D-side controls left asserted-looking but idle
    pend_d = mk(1'b1, 1'b1, 18'd9, 32'hFFFFFFFF);
    pend_d.v = 1'b0;
    pend_i = mk(1'b0, 1'b0, 18'd40, 32'd0);
    run_txn(w);
    chk("oor_port", 32'(w), 32'd0);

    // Reset in the middle of a write access
    pend_d = mk(1'b1, 1'b0, 18'd7, 32'hCAFE0001);
    drive_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("mid_wr_strobe", 32'(mem_memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({mem_memRead, mem_memWrite, mem_byteOperations}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_acks", 32'({i_ack, d_ack, addr_err}), 32'd0);
    chk("mid_rst_bus", 32'(mem_address) | mem_write_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr_m = 1'b1;
    chk("mid_rst_mem_kept", mem_dev[7], mem_ref[7]);
    run_txn(w);
    pend_d = mk(1'b0, 1'b0, 18'd7, 32'd0);
    run_txn(w);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if (!pend_i.v && $urandom_range(0, 1) == 1) pend_i = rand_txn();
      if (!pend_d.v && $urandom_range(0, 1) == 1) pend_d = rand_txn();
      if (!pend_i.v && !pend_d.v) begin
        pend_d = rand_txn();
        pend_d.v = 1'b0;
        pend_i = rand_txn();
      end
      run_txn(w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory between two requesters: instruction fetch (port I, read-only, word) and data access (port D, read/write, word or byte).
- Latches one request, drives the memory strobes for a fixed number of cycles, captures read data and returns a one-cycle acknowledge to the granted port.
- Sits between the fetch/load-store stages and the memory block; it is the only driver of the memory's address, data and strobe inputs.

Parameters:
- ADDR_W, 18, word address width presented to memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles strobes are held before read data is sampled (legal range 1..15).
- MEM_WORDS, 32, number of implemented words; addresses >= MEM_WORDS are out of range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  ADDR_W  fetch word address.
- i_ack  out  1  one-cycle completion pulse for port I.
- i_rdata  out  DATA_W  fetch data, valid while i_ack=1.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_byte  in  1  byte operation (low byte only).
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle completion pulse for port D.
- d_rdata  out  DATA_W  read data, valid while d_ack=1.
- addr_err  out  1  pulses with ack when the completed request was out of range.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write data.
- mem_memRead  out  1  memory read strobe.
- mem_memWrite  out  1  memory write strobe.
- mem_byteOperations  out  1  memory byte-mode select.
- mem_read_data  in  DATA_W  from memory read data.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; latched request cleared; priority pointer set to D. An in-flight transaction is dropped with no ack; the requester re-issues it.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: if any req is high, select a winner (see arbitration), latch address/we/byte/wdata/port into internal registers, clear the counter, go to ACCESS. Request inputs are not sampled outside IDLE.
- ACCESS: drive mem_* from latched values.
  - mem_memRead = ~we; mem_memWrite = we; mem_byteOperations = byte (always 0 for port I).
  - Counter increments each cycle. On the cycle the counter reaches MEM_LAT-1, capture mem_read_data and go to RESP.
  - Out-of-range address: strobes stay 0, data captured as 0, err flag set, still MEM_LAT cycles.
- RESP: strobes 0; assert the granted port's ack for exactly one cycle.
  - Read data: byte reads return {24'b0, captured[7:0]}; word reads return the full word; writes return 0.
  - addr_err mirrors the err flag. Go to IDLE.
- Rdata outputs are 0 whenever their ack is 0.
- Transaction latency from req sampled in IDLE to ack is MEM_LAT+1 cycles. A requester holding req high after ack is re-arbitrated in the following IDLE cycle, giving a back-to-back period of MEM_LAT+2.
- Port I has no write path; d_we/d_byte never affect a port I grant.
- A request whose req drops before ack is still completed and acked (protocol violation, not detected).

Arbitration:
- Default is fixed priority, D over I.
- A simultaneous I and D request in IDLE grants D; I waits.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: one-bit pointer naming the preferred port. On simultaneous requests the preferred port wins, and after each grant the pointer moves to the other port. A lone request is granted regardless of the pointer, and the pointer still toggles away from the winner.
- Undefined: fixed D-over-I priority; the pointer register is absent.

Decomposition:
- Package mem_arb_pkg: FSM state enum (IDLE, ACCESS, RESP), port-id constants PORT_I=0 and PORT_D=1, default widths, and the MEM_LAT counter width constant (4).
- One natural sub-module, mem_arb_select: combinational/registered winner selection including the optional round-robin pointer. The FSM and datapath stay in the top module.

Test Plan:
- Reset mid-ACCESS: assert rst_n=0 while mem_memWrite=1 -> all outputs 0 immediately, no ack, busy=0; after release, the same request completes normally.
- Word read, MEM_LAT=2, memory[5]=32'hDEADBEEF: d_req=1, d_we=0, d_addr=5 -> mem_memRead high 2 cycles; d_ack one cycle with d_rdata=32'hDEADBEEF at cycle 3.
- Byte write then byte read on port D:
  - Write d_wdata=32'h123456A7 to addr 3 -> mem_byteOperations=1, mem_write_data=32'h123456A7, d_ack with d_rdata=0.
  - Read back addr 3 with d_byte=1 -> d_rdata=32'h000000A7.
- Contention: i_req and d_req both high in IDLE, held for 3 transactions each.
  - Fixed priority: acks D,D,D,I,I,I.
  - With MEM_ARB_ROUND_ROBIN_EN: D,I,D,I,D,I.
- Out of range: i_addr=40 with MEM_WORDS=32 -> no strobes, i_ack with i_rdata=0 and addr_err=1 after MEM_LAT+1 cycles.
